// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard control unit: EX operand forward selects
// and the load-use stall FSM states.
package hazard_pkg;

  localparam logic [1:0] FWD_NONE   = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_fwd_lane.sv
// One EX-stage operand forward lane: picks EX/MEM, MEM/WB or the regfile value
// for a single source register. Purely combinational.
module hazard_fwd_lane
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 3
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd,
  input  logic                  ex_mem_regwrite,
  input  logic                  ex_mem_memread,
  input  logic [REG_ADDR_W-1:0] mem_wb_rd,
  input  logic                  mem_wb_regwrite,
  output logic [1:0]            sel
);

  logic ex_mem_hit;
  logic mem_wb_hit;

  // A load in MEM has no result yet, so it can never feed EX directly.
  assign ex_mem_hit = ex_mem_regwrite && !ex_mem_memread &&
                      (ex_mem_rd != '0) && (ex_mem_rd == rs);
  assign mem_wb_hit = mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == rs);

  always_comb begin
    sel = FWD_NONE;
    if (ex_mem_hit) begin
      sel = FWD_EX_MEM;
    end else if (mem_wb_hit) begin
      sel = FWD_MEM_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard control: per-lane RAW forwarding, counted load-use stall FSM and
// branch flush. Define HAZARD_PERF_CNT_EN to build the stall/flush counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W     = 3,
  parameter int NUM_SRC        = 2,
  parameter int LOAD_STALL_CYC = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]            id_rs_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_ex_rs,
  input  logic [REG_ADDR_W-1:0]         id_ex_rd,
  input  logic                          id_ex_memread,
  input  logic [REG_ADDR_W-1:0]         ex_mem_rd,
  input  logic                          ex_mem_regwrite,
  input  logic                          ex_mem_memread,
  input  logic [REG_ADDR_W-1:0]         mem_wb_rd,
  input  logic                          mem_wb_regwrite,
  input  logic                          branch_taken,
  output logic [NUM_SRC*2-1:0]          forward_sel,
  output logic                          stall_pc,
  output logic                          stall_if_id,
  output logic                          flush_if_id,
  output logic                          flush_id_ex,
  output logic [31:0]                   perf_stall_cnt,
  output logic [31:0]                   perf_flush_cnt
);

  // The first bubble is issued from IDLE, so STALL only covers the remainder.
  localparam bit         MULTI_CYC = (LOAD_STALL_CYC > 1);
  localparam logic [2:0] CNT_INIT  = MULTI_CYC ? 3'(LOAD_STALL_CYC - 2) : 3'd0;

  hz_state_t  state;
  logic [2:0] cnt;
  logic       load_use;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
    hazard_fwd_lane #(
      .REG_ADDR_W(REG_ADDR_W)
    ) u_lane (
      .rs             (id_ex_rs[g*REG_ADDR_W +: REG_ADDR_W]),
      .ex_mem_rd      (ex_mem_rd),
      .ex_mem_regwrite(ex_mem_regwrite),
      .ex_mem_memread (ex_mem_memread),
      .mem_wb_rd      (mem_wb_rd),
      .mem_wb_regwrite(mem_wb_regwrite),
      .sel            (forward_sel[g*2 +: 2])
    );
  end

  always_comb begin
    load_use = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_rs_valid[i] && (id_rs[i*REG_ADDR_W +: REG_ADDR_W] == id_ex_rd)) begin
        load_use = 1'b1;
      end
    end
    load_use = load_use && id_ex_memread && (id_ex_rd != '0);
  end

  always_ff @(posedge clk) begin
    if (rst || branch_taken) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_use && MULTI_CYC) begin
            state <= ST_STALL;
            cnt   <= CNT_INIT;
          end
        end
        ST_STALL: begin
          if (cnt == 3'd0) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Branch flush outranks any stall; load_use only matters while IDLE.
  always_comb begin
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (!rst) begin
      if (branch_taken) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if ((state == ST_STALL) || load_use) begin
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_pc) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (branch_taken) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: three instances (1, 3 and 4 stall cycles) share
// inputs and are compared every cycle against a bubble-counting reference model.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] id_rs;
  logic [1:0] id_rs_valid;
  logic [5:0] id_ex_rs;
  logic [2:0] id_ex_rd;
  logic       id_ex_memread;
  logic [2:0] ex_mem_rd;
  logic       ex_mem_regwrite;
  logic       ex_mem_memread;
  logic [2:0] mem_wb_rd;
  logic       mem_wb_regwrite;
  logic       branch_taken;

  logic [3:0]  fsel [3];
  logic        sp   [3];
  logic        sif  [3];
  logic        fif  [3];
  logic        fid  [3];
  logic [31:0] psc  [3];
  logic [31:0] pfc  [3];

  int          total = 0;
  int          bad   = 0;
  int          rem     [3];
  logic [31:0] m_stall [3];
  logic [31:0] m_flush [3];

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_ADDR_W(3), .NUM_SRC(2), .LOAD_STALL_CYC(1)) u_l1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_valid(id_rs_valid), .id_ex_rs(id_ex_rs),
    .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread), .ex_mem_rd(ex_mem_rd),
    .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_memread(ex_mem_memread),
    .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite), .branch_taken(branch_taken),
    .forward_sel(fsel[0]), .stall_pc(sp[0]), .stall_if_id(sif[0]), .flush_if_id(fif[0]),
    .flush_id_ex(fid[0]), .perf_stall_cnt(psc[0]), .perf_flush_cnt(pfc[0]));

  hazard_ctrl_unit #(.REG_ADDR_W(3), .NUM_SRC(2), .LOAD_STALL_CYC(3)) u_l3 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_valid(id_rs_valid), .id_ex_rs(id_ex_rs),
    .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread), .ex_mem_rd(ex_mem_rd),
    .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_memread(ex_mem_memread),
    .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite), .branch_taken(branch_taken),
    .forward_sel(fsel[1]), .stall_pc(sp[1]), .stall_if_id(sif[1]), .flush_if_id(fif[1]),
    .flush_id_ex(fid[1]), .perf_stall_cnt(psc[1]), .perf_flush_cnt(pfc[1]));

  hazard_ctrl_unit #(.REG_ADDR_W(3), .NUM_SRC(2), .LOAD_STALL_CYC(4)) u_l4 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_valid(id_rs_valid), .id_ex_rs(id_ex_rs),
    .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread), .ex_mem_rd(ex_mem_rd),
    .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_memread(ex_mem_memread),
    .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite), .branch_taken(branch_taken),
    .forward_sel(fsel[2]), .stall_pc(sp[2]), .stall_if_id(sif[2]), .flush_if_id(fif[2]),
    .flush_id_ex(fid[2]), .perf_stall_cnt(psc[2]), .perf_flush_cnt(pfc[2]));

  function automatic int stall_len(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [1:0] fwd_ref(input logic [2:0] rs);
    if (ex_mem_regwrite && !ex_mem_memread && ex_mem_rd != 3'd0 && ex_mem_rd == rs)
      return 2'b10;
    if (mem_wb_regwrite && mem_wb_rd != 3'd0 && mem_wb_rd == rs)
      return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit lu_ref();
    bit hit = 1'b0;
    if (id_rs_valid[0] && id_rs[2:0] == id_ex_rd) hit = 1'b1;
    if (id_rs_valid[1] && id_rs[5:3] == id_ex_rd) hit = 1'b1;
    return hit && id_ex_memread && (id_ex_rd != 3'd0);
  endfunction

  function automatic bit stall_ref(input int d);
    return !rst && !branch_taken && (rem[d] > 0 || lu_ref());
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    logic [3:0] efwd;
    bit         est;
    bit         ebr;
    efwd = {fwd_ref(id_ex_rs[5:3]), fwd_ref(id_ex_rs[2:0])};
    ebr  = !rst && branch_taken;
    for (int d = 0; d < 3; d++) begin
      est = stall_ref(d);
      chk($sformatf("fwd_sel[%0d]", d), 32'(fsel[d]), 32'(efwd));
      chk($sformatf("stall_pc[%0d]", d), 32'(sp[d]), 32'(est));
      chk($sformatf("stall_if_id[%0d]", d), 32'(sif[d]), 32'(est));
      chk($sformatf("flush_if_id[%0d]", d), 32'(fif[d]), 32'(ebr));
      chk($sformatf("flush_id_ex[%0d]", d), 32'(fid[d]), 32'(ebr || est));
`ifdef HAZARD_PERF_CNT_EN
      chk($sformatf("perf_stall[%0d]", d), psc[d], m_stall[d]);
      chk($sformatf("perf_flush[%0d]", d), pfc[d], m_flush[d]);
`else
      chk($sformatf("perf_stall[%0d]", d), psc[d], 32'd0);
      chk($sformatf("perf_flush[%0d]", d), pfc[d], 32'd0);
`endif
    end
  endtask

  // Check current outputs, advance the model across the edge, then step the clock.
  task automatic tick();
    bit st;
    #1;
    check_all();
    for (int d = 0; d < 3; d++) begin
      st = stall_ref(d);
      if (rst) begin
        rem[d]     = 0;
        m_stall[d] = 32'd0;
        m_flush[d] = 32'd0;
      end else begin
        if (st) m_stall[d] = m_stall[d] + 32'd1;
        if (branch_taken) m_flush[d] = m_flush[d] + 32'd1;
        if (branch_taken) rem[d] = 0;
        else if (rem[d] > 0) rem[d] = rem[d] - 1;
        else if (lu_ref()) rem[d] = stall_len(d) - 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 6'd0; id_rs_valid = 2'b00; id_ex_rs = 6'd0; id_ex_rd = 3'd0;
    id_ex_memread = 1'b0; ex_mem_rd = 3'd0; ex_mem_regwrite = 1'b0;
    ex_mem_memread = 1'b0; mem_wb_rd = 3'd0; mem_wb_regwrite = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic load_use_on();
    idle();
    id_ex_memread = 1'b1; id_ex_rd = 3'd2; id_rs = {3'd2, 3'd0}; id_rs_valid = 2'b10;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rem[d] = 0; m_stall[d] = 32'd0; m_flush[d] = 32'd0;
    end
    idle();
    rst = 1'b1;
    load_use_on();
    tick();
    tick();
    rst = 1'b0;

    idle();
    id_ex_rs = {3'd0, 3'd3}; ex_mem_rd = 3'd3; mem_wb_rd = 3'd3;
    ex_mem_regwrite = 1'b1; mem_wb_regwrite = 1'b1;
    #1 chk("fwd_prio_exmem", 32'(fsel[0][1:0]), 32'h2);
    tick();
    ex_mem_regwrite = 1'b0;
    #1 chk("fwd_memwb", 32'(fsel[0][1:0]), 32'h1);
    tick();

    idle();
    id_ex_rs = {3'd0, 3'd1}; ex_mem_rd = 3'd0; ex_mem_regwrite = 1'b1;
    #1 chk("fwd_x0", 32'(fsel[0][3:2]), 32'h0);
    tick();
    idle();
    id_ex_rs = {3'd0, 3'd5}; ex_mem_rd = 3'd5; ex_mem_regwrite = 1'b1; ex_mem_memread = 1'b1;
    #1 chk("fwd_load_supp", 32'(fsel[0][1:0]), 32'h0);
    tick();

    load_use_on();
    #1 chk("lu_l1_first", 32'(sp[0]), 32'h1);
    tick();
    idle();
    #1 chk("lu_l1_done", 32'(sp[0]), 32'h0);
    chk("lu_l3_cont", 32'(sp[1]), 32'h1);
    tick(); tick(); tick(); tick();

    load_use_on();
    id_rs_valid = 2'b00;
    #1 chk("lu_invalid_lane", 32'(sp[0]), 32'h0);
    tick();

    load_use_on();
    tick();
    idle();
    branch_taken = 1'b1;
    #1 chk("br_flush_if_id", 32'(fif[1]), 32'h1);
    chk("br_no_stall", 32'(sp[1]), 32'h0);
    tick();
    branch_taken = 1'b0;
    #1 chk("br_then_idle", 32'(sp[1]), 32'h0);
    tick();

    load_use_on();
    tick();
    idle();
    rst = 1'b1;
    #1 chk("rst_mid_stall", 32'(sp[2]), 32'h0);
    tick();
    rst = 1'b0;
    #1 chk("rst_then_idle", 32'(sp[2]), 32'h0);
    tick();

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int h = 0; h < 2; h++) begin
      load_use_on();
      tick();
      idle();
      tick(); tick(); tick();
    end
    branch_taken = 1'b1;
    tick();
    idle();
    #1;
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall_l3", psc[1], 32'd6);
    chk("perf_flush_l3", pfc[1], 32'd1);
`else
    chk("perf_stall_off", psc[1], 32'd0);
    chk("perf_flush_off", pfc[1], 32'd0);
`endif
    tick();

    for (int n = 0; n < 400; n++) begin
      rst             = ($urandom_range(0, 39) == 0);
      id_rs           = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))};
      id_rs_valid     = 2'($urandom);
      id_ex_rs        = {3'($urandom_range(0, 4)), 3'($urandom_range(0, 4))};
      id_ex_rd        = 3'($urandom_range(0, 3));
      id_ex_memread   = ($urandom_range(0, 2) == 0);
      ex_mem_rd       = 3'($urandom_range(0, 4));
      ex_mem_regwrite = 1'($urandom);
      ex_mem_memread  = ($urandom_range(0, 3) == 0);
      mem_wb_rd       = 3'($urandom_range(0, 4));
      mem_wb_regwrite = 1'($urandom);
      branch_taken    = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised successor to the data-memory forwarding unit for the pipelined core. It combines three functions:
- Per-operand RAW forwarding selection for the EX stage.
- Load-use hazard detection with a counted multi-cycle stall FSM.
- Branch-taken flush control.
It sits between the ID/EX, EX/MEM and MEM/WB pipeline registers and drives PC/IF-ID stall enables, pipeline flush/bubble controls and EX-stage operand muxes.

Parameters:
- REG_ADDR_W, 3, register address width; register 0 is hardwired zero and is never forwarded or stalled on.
- NUM_SRC, 2, source operands per instruction (forward lanes).
- LOAD_STALL_CYC, 1, bubble cycles inserted per load-use hazard; legal range 1..7.

Ports:
- clk  in  1  clock; everything on posedge.
- rst  in  1  synchronous active-high reset.
- id_rs  in  NUM_SRC*REG_ADDR_W  source register addresses in ID; lane i at [i*REG_ADDR_W +: REG_ADDR_W].
- id_rs_valid  in  NUM_SRC  lane i in ID actually reads a register.
- id_ex_rs  in  NUM_SRC*REG_ADDR_W  source register addresses of the instruction in EX.
- id_ex_rd  in  REG_ADDR_W  destination of the instruction in EX.
- id_ex_memread  in  1  instruction in EX is a load.
- ex_mem_rd  in  REG_ADDR_W  destination in MEM.
- ex_mem_regwrite  in  1  instruction in MEM writes a register.
- ex_mem_memread  in  1  instruction in MEM is a load.
- mem_wb_rd  in  REG_ADDR_W  destination in WB.
- mem_wb_regwrite  in  1  instruction in WB writes a register.
- branch_taken  in  1  taken-branch resolution from EX.
- forward_sel  out  NUM_SRC*2  per-lane select: 00 regfile, 01 MEM/WB, 10 EX/MEM.
- stall_pc  out  1  hold PC.
- stall_if_id  out  1  hold the IF/ID register.
- flush_if_id  out  1  clear the IF/ID register.
- flush_id_ex  out  1  inject a bubble into ID/EX.
- perf_stall_cnt  out  32  stall-cycle count (see Optional Feature).
- perf_flush_cnt  out  32  branch-flush count (see Optional Feature).

Behaviour:
- Forwarding: combinational, zero latency, evaluated independently per lane.
  - Select 10 when ex_mem_regwrite && !ex_mem_memread && ex_mem_rd != 0 && ex_mem_rd == lane rs.
  - Otherwise select 01 when mem_wb_regwrite && mem_wb_rd != 0 && mem_wb_rd == lane rs.
  - Otherwise 00.
  - EX/MEM has priority over MEM/WB when both match.
  - Forwarding does not depend on rst.
- load_use: id_ex_memread && id_ex_rd != 0 && any lane i has id_rs_valid[i] && id_rs[i] == id_ex_rd.
- FSM states: IDLE, STALL; 3-bit down-counter cnt.
  - IDLE, no branch_taken, load_use=1: outputs stall_pc = stall_if_id = flush_id_ex = 1 in the same cycle.
    - If LOAD_STALL_CYC > 1: next state STALL, cnt <= LOAD_STALL_CYC-2.
    - Otherwise remain IDLE.
  - STALL: outputs stall_pc = stall_if_id = flush_id_ex = 1.
    - If cnt == 0, next state IDLE; otherwise cnt <= cnt-1.
    - load_use is ignored while in STALL.
  - Total bubble cycles per hazard = LOAD_STALL_CYC exactly.
- branch_taken: flush_if_id = flush_id_ex = 1 in the same cycle; stall_pc = stall_if_id = 0.
  - Takes priority over load_use and over STALL.
  - Forces the FSM to IDLE and clears cnt.
- Reset: while rst=1, all stall/flush outputs are 0; state <= IDLE and cnt <= 0 at the edge.
  - Reset asserted mid-stall aborts the stall; the first cycle after release is IDLE.
- No registered outputs other than FSM-derived ones; flush/stall outputs are Mealy-style from state plus inputs.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - perf_stall_cnt increments on every cycle with stall_pc=1.
  - perf_flush_cnt increments on every cycle with branch_taken=1.
  - Both are 32-bit, wrap modulo 2^32 and are cleared by rst.
- Undefined: both ports are tied to 32'd0 and no counter flops exist.

Decomposition:
- Shared package hazard_pkg holds:
  - FWD_NONE=2'b00, FWD_MEM_WB=2'b01, FWD_EX_MEM=2'b10.
  - The FSM state encoding ST_IDLE / ST_STALL.
- One sub-module, hazard_fwd_lane: per-lane combinational priority select, instantiated NUM_SRC times by generate.

Test Plan:
- Forward priority: ex_mem_rd=3, mem_wb_rd=3, both regwrite=1, id_ex_rs lane0=3 -> forward_sel[1:0]=10. Same with ex_mem_regwrite=0 -> 01.
- x0 and load suppression: ex_mem_rd=0 matching lane1 rs=0 -> 00. ex_mem_memread=1 with ex_mem_rd=5 matching and no MEM/WB match -> 00.
- Load-use, LOAD_STALL_CYC=1: id_ex_memread=1, id_ex_rd=2, id_rs lane1=2 valid -> stall_pc = stall_if_id = flush_id_ex = 1 for exactly 1 cycle. With id_rs_valid[1]=0 -> no stall.
- LOAD_STALL_CYC=3: a load_use pulse for one cycle -> stall outputs high for exactly 3 consecutive cycles. branch_taken in cycle 2 -> flush_if_id=1, stall_pc=0, FSM in IDLE the next cycle.
- Reset mid-stall: LOAD_STALL_CYC=4, assert rst in the 2nd stall cycle -> outputs 0 that cycle and IDLE afterwards.
- HAZARD_PERF_CNT_EN defined: 2 hazards at LOAD_STALL_CYC=3 plus 1 branch -> perf_stall_cnt=6, perf_flush_cnt=1. Undefined -> both read 0.
